// File: rtl/wave_meas_pkg.sv
// Shared definitions for the waveform analyser: register map, CTRL bit
// positions and FSM state encoding.
package wave_meas_pkg;

   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_THRESH  = 3'd1;
   localparam logic [2:0] REG_PERIOD  = 3'd2;
   localparam logic [2:0] REG_HIGH    = 3'd3;
   localparam logic [2:0] REG_MIN     = 3'd4;
   localparam logic [2:0] REG_MAX     = 3'd5;
   localparam logic [2:0] REG_TIMEOUT = 3'd6;

   localparam int CTRL_START = 0;
   localparam int CTRL_CONT  = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_HIGH      = 3'd3,
      ST_LOW       = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   // A measurement is in flight from arming until it completes or times out.
   function automatic logic is_busy(input state_t s);
      return (s == ST_ARM) || (s == ST_WAIT_RISE) || (s == ST_HIGH) || (s == ST_LOW);
   endfunction

endpackage

// File: rtl/wave_meas_edge_det.sv
// Threshold slicer: registers the wave sample once, compares it against the
// threshold and produces the level plus single-cycle rise/fall indications.
module wave_meas_edge_det (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wave_in,
   input  logic [31:0] thresh,
   output logic [31:0] wave_q,
   output logic        lvl,
   output logic        rise,
   output logic        fall
);

   logic lvl_q;

   // Sample register for the wave and history of the sliced level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wave_q <= '0;
         lvl_q  <= 1'b0;
      end else begin
         wave_q <= wave_in;
         lvl_q  <= lvl;
      end
   end

   // Unsigned compare against the live threshold register.
   assign lvl  = (wave_q > thresh);
   assign rise = lvl & ~lvl_q;
   assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/wave_meas.sv
// Memory-mapped waveform analyser: slices the wave against a threshold and
// measures high time, period and min/max sample value.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | nothing armed, results held
//  ARM        | armed, waiting for the level to be low
//  WAIT_RISE  | level seen low, waiting for a true rising edge
//  HIGH       | counting the high part of the cycle
//  LOW        | counting the low part, next rise completes the period
//  DONE       | measurement finished or timed out, results held
module wave_meas
   import wave_meas_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [31:0] wave_in,
   output logic        irq
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic [31:0]      cnt_ext;

   logic [31:0]      thresh;
   logic [31:0]      timeout_val;
   logic [31:0]      min_val;
   logic [31:0]      max_val;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_t;
   logic             cont;
   logic             valid;
   logic             to_flag;

   logic [31:0]      wave_q;
   logic             lvl;
   logic             rise;
   logic             fall;

   logic [2:0]       reg_sel;
   logic             we;
   logic             ctrl_we;
   logic             start;
   logic             busy;
   logic             timeout_hit;

   logic             arm;
   logic             latch_high;
   logic             latch_period;
   logic             set_timeout;
   logic             irq_nxt;

   logic             unused_addr;

   assign reg_sel     = addr[4:2];
   assign unused_addr = ^{addr[31:5], addr[1:0]};
   assign we          = |wstrb;
   assign ctrl_we     = we && (reg_sel == REG_CTRL);
   assign start       = wdata[CTRL_START];
   assign busy        = is_busy(state);

   assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   assign cnt_ext     = 32'(cnt);
   assign timeout_hit = (timeout_val != '0) && (cnt_ext >= timeout_val);

   wave_meas_edge_det u_edge (
      .clk     (clk),
      .reset   (reset),
      .wave_in (wave_in),
      .thresh  (thresh),
      .wave_q  (wave_q),
      .lvl     (lvl),
      .rise    (rise),
      .fall    (fall)
   );

   // State and shared time counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; a CTRL write overrides any same-cycle edge or timeout.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt_inc;
      arm          = 1'b0;
      latch_high   = 1'b0;
      latch_period = 1'b0;
      set_timeout  = 1'b0;
      irq_nxt      = 1'b0;
      if (ctrl_we && start) begin
         state_nxt = ST_ARM;
         cnt_nxt   = '0;
         arm       = 1'b1;
      end else if (ctrl_we && busy) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               cnt_nxt = '0;
            end
            ST_ARM: begin
               if (timeout_hit) begin
                  set_timeout = 1'b1;
                  irq_nxt     = 1'b1;
                  state_nxt   = ST_DONE;
               end else if (!lvl) begin
                  state_nxt = ST_WAIT_RISE;
                  cnt_nxt   = '0;
               end
            end
            ST_WAIT_RISE: begin
               if (timeout_hit) begin
                  set_timeout = 1'b1;
                  irq_nxt     = 1'b1;
                  state_nxt   = ST_DONE;
               end else if (rise) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (timeout_hit) begin
                  set_timeout = 1'b1;
                  irq_nxt     = 1'b1;
                  state_nxt   = ST_DONE;
               end else if (fall) begin
                  latch_high = 1'b1;
                  state_nxt  = ST_LOW;
               end
            end
            ST_LOW: begin
               if (timeout_hit) begin
                  set_timeout = 1'b1;
                  irq_nxt     = 1'b1;
                  state_nxt   = ST_DONE;
               end else if (rise) begin
                  latch_period = 1'b1;
                  irq_nxt      = 1'b1;
                  if (cont) begin
                     state_nxt = ST_HIGH;
                     cnt_nxt   = CNT_W'(1);
                  end else begin
                     state_nxt = ST_DONE;
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Configuration registers, result registers, status flags and irq pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         thresh      <= '0;
         timeout_val <= '0;
         cont        <= 1'b0;
         valid       <= 1'b0;
         to_flag     <= 1'b0;
         period      <= '0;
         high_t      <= '0;
         min_val     <= '0;
         max_val     <= '0;
         irq         <= 1'b0;
      end else begin
         irq <= irq_nxt;
         if (ctrl_we) begin
            cont <= wdata[CTRL_CONT];
         end
         if (we && (reg_sel == REG_THRESH)) begin
            thresh <= wdata;
         end
         if (we && (reg_sel == REG_TIMEOUT)) begin
            timeout_val <= wdata;
         end
         if (arm) begin
            valid   <= 1'b0;
            to_flag <= 1'b0;
            min_val <= '1;
            max_val <= '0;
         end else begin
            if ((state == ST_HIGH) || (state == ST_LOW)) begin
               if (wave_q < min_val) begin
                  min_val <= wave_q;
               end
               if (wave_q > max_val) begin
                  max_val <= wave_q;
               end
            end
            if (latch_high) begin
               high_t <= cnt;
            end
            if (latch_period) begin
               period <= cnt;
               valid  <= 1'b1;
            end
            if (set_timeout) begin
               to_flag <= 1'b1;
            end
         end
      end
   end

   // Combinational read mux; unmapped offset reads zero.
   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_CTRL:    rdata = {27'b0, busy, to_flag, valid, cont, 1'b0};
         REG_THRESH:  rdata = thresh;
         REG_PERIOD:  rdata = 32'(period);
         REG_HIGH:    rdata = 32'(high_t);
         REG_MIN:     rdata = min_val;
         REG_MAX:     rdata = max_val;
         REG_TIMEOUT: rdata = timeout_val;
         default:     rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_wave_meas.sv
// Directed bench for wave_meas: a small in-bench wave generator drives
// square/rect patterns, and expected register values are hand-computed.
module tb_wave_meas;

   logic        clk;
   logic        reset;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] wave_in;
   logic        irq;

   int n_chk = 0;
   int n_bad = 0;
   int irq_cnt = 0;

   int          gen_id = 0;
   int          gen_hi = 0;
   int          gen_lo = 0;
   logic [31:0] gen_amp = '0;

   wave_meas #(.CNT_W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .wave_in (wave_in),
      .irq     (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wave generator: gen_hi==0 gives a constant gen_amp, otherwise gen_amp for
   // gen_hi cycles then 0 for gen_lo cycles; a new gen_id restarts the phase.
   initial begin
      int phase = 0;
      int seen = 0;
      forever begin
         @(posedge clk);
         #1;
         if (gen_id != seen) begin
            seen  = gen_id;
            phase = 0;
         end
         if (gen_hi == 0) begin
            wave_in = gen_amp;
         end else begin
            wave_in = (phase < gen_hi) ? gen_amp : 32'd0;
            phase   = (phase + 1) % (gen_hi + gen_lo);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (irq === 1'b1) irq_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
      @(negedge clk);
      addr  = {27'b0, idx, 2'b00};
      wdata = d;
      wstrb = 4'hF;
      @(negedge clk);
      wstrb = 4'h0;
   endtask

   task automatic bus_read(input logic [2:0] idx, output logic [31:0] d);
      @(negedge clk);
      addr = {27'b0, idx, 2'b00};
      #1;
      d = rdata;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(idx, d);
      chk(tag, d, exp);
   endtask

   task automatic wait_irq(input int budget, output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (irq === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_wave(input string tag, input logic [31:0] val, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (wave_in === val) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic set_gen(input int hi, input int lo, input logic [31:0] amp);
      gen_hi  = hi;
      gen_lo  = lo;
      gen_amp = amp;
      gen_id++;
   endtask

   initial begin
      int cyc;
      bit seen;
      int n0;

      reset = 1'b1;
      wstrb = 4'h0;
      addr  = '0;
      wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_irq", 32'(irq), 32'd0);
      for (int r = 0; r < 8; r++) begin
         chk_reg($sformatf("rst_reg%0d", r), 3'(r), 32'd0);
      end
      reset = 1'b0;

      // register access
      bus_write(REG_SEL(1), 32'h0000_00AB);
      chk_reg("thresh_rw", 3'd1, 32'h0000_00AB);
      bus_write(3'd2, 32'h0000_0055);
      chk_reg("period_ro", 3'd2, 32'd0);
      bus_write(3'd7, 32'hFFFF_FFFF);
      chk_reg("reg7_zero", 3'd7, 32'd0);
      bus_write(3'd1, 32'd0);

      // toggle 5/5 single shot
      set_gen(5, 5, 32'd1);
      repeat (4) @(negedge clk);
      n0 = irq_cnt;
      bus_write(3'd0, 32'h1);
      chk_reg("tog_busy", 3'd0, 32'h10);
      wait_irq(60, cyc, seen);
      chk("tog_irq", 32'(seen), 32'd1);
      repeat (30) @(negedge clk);
      chk("tog_irq_cnt", 32'(irq_cnt - n0), 32'd1);
      chk_reg("tog_period", 3'd2, 32'd10);
      chk_reg("tog_high", 3'd3, 32'd5);
      chk_reg("tog_ctrl", 3'd0, 32'h04);
      chk_reg("tog_min", 3'd4, 32'd0);
      chk_reg("tog_max", 3'd5, 32'd1);

      // pwm 3/7 continuous
      set_gen(3, 7, 32'd1);
      bus_write(3'd0, 32'h3);
      wait_irq(60, cyc, seen);
      chk("pwm_irq", 32'(seen), 32'd1);
      wait_irq(30, cyc, seen);
      chk("pwm_gap1", 32'(cyc), 32'd10);
      wait_irq(30, cyc, seen);
      chk("pwm_gap2", 32'(cyc), 32'd10);
      chk_reg("pwm_period", 3'd2, 32'd10);
      chk_reg("pwm_high", 3'd3, 32'd3);
      chk_reg("pwm_ctrl", 3'd0, 32'h16);
      bus_write(3'd0, 32'h0);
      chk_reg("pwm_stop", 3'd0, 32'h04);

      // rect 1000, 10/10, threshold 500
      set_gen(10, 10, 32'd1000);
      bus_write(3'd1, 32'd500);
      bus_write(3'd0, 32'h1);
      wait_irq(80, cyc, seen);
      chk("rect_irq", 32'(seen), 32'd1);
      chk_reg("rect_period", 3'd2, 32'd20);
      chk_reg("rect_high", 3'd3, 32'd10);
      chk_reg("rect_min", 3'd4, 32'd0);
      chk_reg("rect_max", 3'd5, 32'd1000);

      // timeout with wave stuck low
      set_gen(0, 0, 32'd0);
      bus_write(3'd1, 32'd0);
      bus_write(3'd6, 32'd100);
      bus_write(3'd0, 32'h1);
      wait_irq(200, cyc, seen);
      chk("to_irq", 32'(seen), 32'd1);
      chk("to_irq_time", 32'(cyc >= 95 && cyc <= 110), 32'd1);
      chk_reg("to_ctrl", 3'd0, 32'h08);
      chk_reg("to_period_kept", 3'd2, 32'd20);
      chk_reg("to_reg", 3'd6, 32'd100);
      bus_write(3'd6, 32'd0);

      // abort mid-HIGH
      set_gen(5, 5, 32'd1);
      bus_write(3'd0, 32'h1);
      wait_wave("ab_low", 32'd0, 30);
      wait_wave("ab_rise", 32'd1, 30);
      repeat (3) @(negedge clk);
      n0 = irq_cnt;
      bus_write(3'd0, 32'h0);
      repeat (30) @(negedge clk);
      chk("ab_no_irq", 32'(irq_cnt - n0), 32'd0);
      chk_reg("ab_ctrl", 3'd0, 32'h00);
      chk_reg("ab_period_kept", 3'd2, 32'd20);

      // reset mid-LOW
      bus_write(3'd0, 32'h1);
      wait_wave("rl_low", 32'd0, 30);
      wait_wave("rl_rise", 32'd1, 30);
      wait_wave("rl_fall", 32'd0, 30);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rl_irq", 32'(irq), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_reg("rl_ctrl", 3'd0, 32'h00);
      chk_reg("rl_period", 3'd2, 32'd0);
      chk_reg("rl_high", 3'd3, 32'd0);
      chk_reg("rl_min", 3'd4, 32'd0);

      // arm while level already high
      set_gen(0, 0, 32'd1);
      repeat (5) @(negedge clk);
      n0 = irq_cnt;
      bus_write(3'd0, 32'h1);
      repeat (20) @(negedge clk);
      chk("hi_no_irq", 32'(irq_cnt - n0), 32'd0);
      chk_reg("hi_busy", 3'd0, 32'h10);
      set_gen(4, 6, 32'd1);
      wait_irq(60, cyc, seen);
      chk("hi_irq", 32'(seen), 32'd1);
      chk_reg("hi_period", 3'd2, 32'd10);
      chk_reg("hi_high", 3'd3, 32'd4);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   function automatic logic [2:0] REG_SEL(input int i);
      return 3'(i);
   endfunction

endmodule
